regfile_sb: RTL and testbench

- Parametrised successor to the processor's integer register file, used by both the single-cycle and multi-cycle cores.
- Provides NREGS x XLEN storage, two read ports and one write port, with register 0 hardwired to zero.
- Sign/zero extension of load data is applied at write time, with optional write-to-read bypass and optional registered reads.
- A per-register scoreboard (busy bits) lets the multi-cycle control unit detect reads of registers with pending writebacks.

---
 rtl/regfile_sb.sv | 124 ++++++++++++
 tb/tb_regfile_sb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with write-time load extension, optional bypass and
// registered reads, plus a busy-bit scoreboard for pending writebacks.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int AW       = $clog2(NREGS),
   parameter int BYPASS   = 1,
   parameter int REG_READ = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   input  logic            rd_req,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rd_valid,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic [1:0]      wr_size,
   input  logic            wr_unsigned,
   input  logic            rsv_en,
   input  logic [AW-1:0]   rsv_addr,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            any_busy
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;
   logic [XLEN-1:0]  ext_data;
   logic [XLEN-1:0]  rs1_comb;
   logic [XLEN-1:0]  rs2_comb;
   logic             wr_hit;
   logic             rsv_hit;
   logic             byp1;
   logic             byp2;
   logic             fill_b;
   logic             fill_h;

   assign wr_hit  = wr_en && (wr_addr != '0);
   assign rsv_hit = rsv_en && (rsv_addr != '0);
   assign fill_b  = ~wr_unsigned & wr_data[7];
   assign fill_h  = ~wr_unsigned & wr_data[15];

   always_comb begin
      case (wr_size)
         2'b00:   ext_data = {{(XLEN-8){fill_b}}, wr_data[7:0]};
         2'b01:   ext_data = {{(XLEN-16){fill_h}}, wr_data[15:0]};
         default: ext_data = wr_data;
      endcase
   end

   assign byp1     = (BYPASS != 0) && wr_hit && (wr_addr == rs1_addr);
   assign byp2     = (BYPASS != 0) && wr_hit && (wr_addr == rs2_addr);
   assign rs1_comb = byp1 ? ext_data : regs[rs1_addr];
   assign rs2_comb = byp2 ? ext_data : regs[rs2_addr];

   // A same-address reserve keeps the bit set, so only hide busy when no new producer issued.
   assign rs1_busy = busy[rs1_addr] & ~(byp1 & ~(rsv_hit && (rsv_addr == rs1_addr)));
   assign rs2_busy = busy[rs2_addr] & ~(byp2 & ~(rsv_hit && (rsv_addr == rs2_addr)));
   assign any_busy = |busy;

   // Clear on writeback first, then set on reserve so the reserve wins on a collision.
   always_comb begin
      busy_next = busy;
      if (wr_hit) begin
         busy_next[wr_addr] = 1'b0;
      end
      if (rsv_hit) begin
         busy_next[rsv_addr] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         busy <= '0;
      end else begin
         if (wr_hit) begin
            regs[wr_addr] <= ext_data;
         end
         busy <= busy_next;
      end
   end

   generate
      if (REG_READ != 0) begin : g_reg_read
         logic [XLEN-1:0] rs1_q;
         logic [XLEN-1:0] rs2_q;
         logic            valid_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               rs1_q   <= '0;
               rs2_q   <= '0;
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_req;
               if (rd_req) begin
                  rs1_q <= rs1_comb;
                  rs2_q <= rs2_comb;
               end
            end
         end

         assign rs1_data = rs1_q;
         assign rs2_data = rs2_q;
         assign rd_valid = valid_q;
      end else begin : g_comb_read
         logic unused_rd_req;
         assign unused_rd_req = rd_req;
         assign rs1_data      = rs1_comb;
         assign rs2_data      = rs2_comb;
         assign rd_valid      = 1'b1;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one combinational-read instance with bypass
// and one registered-read instance sharing the same stimulus.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_addr, rs2_addr, wr_addr, rsv_addr;
   logic        rd_req, wr_en, wr_unsigned, rsv_en;
   logic [31:0] wr_data;
   logic [1:0]  wr_size;

   logic [31:0] rs1_data, rs2_data, r_rs1_data, r_rs2_data;
   logic        rd_valid, rs1_busy, rs2_busy, any_busy;
   logic        r_rd_valid, r_rs1_busy, r_rs2_busy, r_any_busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1), .REG_READ(0)) dut (
      .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_req(rd_req),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size),
      .wr_unsigned(wr_unsigned), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .any_busy(any_busy)
   );

   regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1), .REG_READ(1)) dut_r (
      .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_req(rd_req),
      .rs1_data(r_rs1_data), .rs2_data(r_rs2_data), .rd_valid(r_rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size),
      .wr_unsigned(wr_unsigned), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .rs1_busy(r_rs1_busy), .rs2_busy(r_rs2_busy), .any_busy(r_any_busy)
   );

   typedef struct {
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic [31:0] wr_data;
      logic [1:0]  wr_size;
      logic        wr_unsigned;
      logic        rsv_en;
      logic [4:0]  rsv_addr;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic        e_b1;
      logic        e_b2;
      logic        e_any;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [1:0] ws, input logic wu, input logic re,
                               input logic [4:0] ra, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [31:0] e1, input logic [31:0] e2,
                               input logic b1, input logic b2, input logic ab);
      vec_t v;
      v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_size = ws; v.wr_unsigned = wu;
      v.rsv_en = re; v.rsv_addr = ra; v.rs1_addr = a1; v.rs2_addr = a2;
      v.e_rs1 = e1; v.e_rs2 = e2; v.e_b1 = b1; v.e_b2 = b2; v.e_any = ab;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0; rd_req = 1'b0;
      wr_addr = 5'd0; wr_data = 32'd0; wr_size = 2'b10; wr_unsigned = 1'b0; rsv_addr = 5'd0;
   endtask

   task automatic apply_stimulus(input vec_t v);
      wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data; wr_size = v.wr_size;
      wr_unsigned = v.wr_unsigned; rsv_en = v.rsv_en; rsv_addr = v.rsv_addr;
      rs1_addr = v.rs1_addr; rs2_addr = v.rs2_addr;
   endtask

   initial begin
      set_idle();
      rst = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      check_output("reset_rs1_data", rs1_data, 32'd0);
      check_output("reset_rs1_busy", {31'd0, rs1_busy}, 32'd0);
      check_output("reset_any_busy", {31'd0, any_busy}, 32'd0);
      check_output("reset_comb_valid", {31'd0, rd_valid}, 32'd1);
      check_output("reset_reg_valid", {31'd0, r_rd_valid}, 32'd0);
      check_output("reset_reg_rs1", r_rs1_data, 32'd0);

      // Stores visible in the write cycle through the bypass, then from storage.
      vecs[0]  = mk(1'b1, 5'd3, 32'h000080F0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 32'hFFFFFFF0, 32'h0, 1'b0, 1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 5'd0, 32'h0,        2'b10, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 32'hFFFFFFF0, 32'h0, 1'b0, 1'b0, 1'b0);
      vecs[2]  = mk(1'b1, 5'd3, 32'h000080F0, 2'b01, 1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 32'h000080F0, 32'h0, 1'b0, 1'b0, 1'b0);
      vecs[3]  = mk(1'b1, 5'd3, 32'h000080F0, 2'b01, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3, 32'hFFFF80F0, 32'hFFFF80F0, 1'b0, 1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 5'd0, 32'h0,        2'b10, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 32'hFFFF80F0, 32'h0, 1'b0, 1'b0, 1'b0);
      vecs[5]  = mk(1'b1, 5'd6, 32'hDEAD80F0, 2'b11, 1'b0, 1'b0, 5'd0, 5'd6, 5'd3, 32'hDEAD80F0, 32'hFFFF80F0, 1'b0, 1'b0, 1'b0);
      vecs[6]  = mk(1'b1, 5'd0, 32'h12345678, 2'b10, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      vecs[7]  = mk(1'b0, 5'd0, 32'h0,        2'b10, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, 32'h0, 32'hDEAD80F0, 1'b0, 1'b0, 1'b0);
      vecs[8]  = mk(1'b1, 5'd7, 32'h00000011, 2'b10, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(1'b1, 5'd7, 32'h00000022, 2'b10, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 1'b0, 1'b0, 1'b0);
      vecs[10] = mk(1'b0, 5'd0, 32'h0,        2'b10, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 1'b0, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 5'd0, 32'h0,        2'b10, 1'b0, 1'b1, 5'd9, 5'd0, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      vecs[12] = mk(1'b1, 5'd9, 32'h00000099, 2'b10, 1'b0, 1'b1, 5'd9, 5'd0, 5'd9, 32'h0, 32'h99, 1'b0, 1'b1, 1'b1);
      vecs[13] = mk(1'b0, 5'd0, 32'h0,        2'b10, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h99, 1'b0, 1'b1, 1'b1);
      vecs[14] = mk(1'b1, 5'd9, 32'h000000AB, 2'b10, 1'b0, 1'b0, 5'd0, 5'd9, 5'd9, 32'hAB, 32'hAB, 1'b0, 1'b0, 1'b1);
      vecs[15] = mk(1'b0, 5'd0, 32'h0,        2'b10, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'hAB, 1'b0, 1'b0, 1'b0);
      vecs[16] = mk(1'b1, 5'd11, 32'h00000005, 2'b10, 1'b0, 1'b1, 5'd10, 5'd11, 5'd10, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0);
      vecs[17] = mk(1'b0, 5'd0, 32'h0,        2'b10, 1'b0, 1'b0, 5'd0, 5'd11, 5'd10, 32'h5, 32'h0, 1'b0, 1'b1, 1'b1);
      vecs[18] = mk(1'b1, 5'd12, 32'h00000001, 2'b10, 1'b0, 1'b0, 5'd0, 5'd12, 5'd10, 32'h1, 32'h0, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 19; i++) begin
         apply_stimulus(vecs[i]);
         #1;
         check_output($sformatf("v%0d_rs1_data", i), rs1_data, vecs[i].e_rs1);
         check_output($sformatf("v%0d_rs2_data", i), rs2_data, vecs[i].e_rs2);
         check_output($sformatf("v%0d_rs1_busy", i), {31'd0, rs1_busy}, {31'd0, vecs[i].e_b1});
         check_output($sformatf("v%0d_rs2_busy", i), {31'd0, rs2_busy}, {31'd0, vecs[i].e_b2});
         check_output($sformatf("v%0d_any_busy", i), {31'd0, any_busy}, {31'd0, vecs[i].e_any});
         next_cycle();
      end
      set_idle();

      // Registered read: data and valid arrive one edge after rd_req, then hold.
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5A5A5A5; wr_size = 2'b10;
      next_cycle();
      set_idle();
      rd_req = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd7;
      #1;
      check_output("rr_valid_before", {31'd0, r_rd_valid}, 32'd0);
      next_cycle();
      check_output("rr_rs1_data", r_rs1_data, 32'hA5A5A5A5);
      check_output("rr_rs2_data", r_rs2_data, 32'h22);
      check_output("rr_valid", {31'd0, r_rd_valid}, 32'd1);
      rd_req = 1'b0; rs1_addr = 5'd3;
      next_cycle();
      check_output("rr_valid_drop", {31'd0, r_rd_valid}, 32'd0);
      check_output("rr_rs1_hold", r_rs1_data, 32'hA5A5A5A5);
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h00000077; rd_req = 1'b1; rs1_addr = 5'd4;
      next_cycle();
      set_idle();
      check_output("rr_bypass_data", r_rs1_data, 32'h77);
      check_output("rr_bypass_valid", {31'd0, r_rd_valid}, 32'd1);

      // Reset with pending reservations and a competing write discards everything.
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_size = 2'b10;
      next_cycle();
      set_idle();
      rsv_en = 1'b1; rsv_addr = 5'd5; rs1_addr = 5'd5;
      next_cycle();
      set_idle();
      #1;
      check_output("pre_rst_rs1_data", rs1_data, 32'hDEADBEEF);
      check_output("pre_rst_rs1_busy", {31'd0, rs1_busy}, 32'd1);
      rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55555555;
      rsv_en = 1'b1; rsv_addr = 5'd6; rd_req = 1'b1;
      next_cycle();
      set_idle();
      #1;
      check_output("rst_rs1_data", rs1_data, 32'd0);
      check_output("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
      check_output("rst_any_busy", {31'd0, any_busy}, 32'd0);
      check_output("rst_reg_valid", {31'd0, r_rd_valid}, 32'd0);
      check_output("rst_reg_rs1", r_rs1_data, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
